ycr1_timer_arb: RTL and testbench

Two-requester arbiter and sequencer in front of ycr1_timer's memory-mapped port.
- Master 0 is the core dmem path; master 1 is the auxiliary/debug path.
- The block grants one master at a time using round-robin, replays the latched request into the timer, and returns the timer response to the owner.
- A response timeout returns an error for requests the timer acknowledges but never answers, such as wrong width or an out-of-range address.

---
 rtl/ycr1_timer_arb_pkg.sv | 47 ++++
 rtl/ycr1_rr_arb2.sv | 19 +
 rtl/ycr1_timer_arb.sv | 170 +++++++++++++++++
 tb/tb_ycr1_timer_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycr1_timer_arb_pkg.sv
// Shared memory-interface types for the timer arbiter and sibling MMIO arbiters.
// Holds the command/width/response encodings, the arbiter state enum and the latched request.
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

package ycr1_timer_arb_pkg;

   localparam int DMEM_AWIDTH = `YCR1_DMEM_AWIDTH;
   localparam int DMEM_DWIDTH = `YCR1_DMEM_DWIDTH;

   typedef enum logic {
      YCR1_MEM_CMD_RD = 1'b0,
      YCR1_MEM_CMD_WR = 1'b1
   } type_ycr1_mem_cmd_e;

   typedef enum logic [1:0] {
      YCR1_MEM_WIDTH_BYTE  = 2'b00,
      YCR1_MEM_WIDTH_HWORD = 2'b01,
      YCR1_MEM_WIDTH_WORD  = 2'b10,
      YCR1_MEM_WIDTH_ERROR = 2'b11
   } type_ycr1_mem_width_e;

   typedef enum logic [1:0] {
      YCR1_MEM_RESP_NOTRDY = 2'b00,
      YCR1_MEM_RESP_RDY_OK = 2'b01,
      YCR1_MEM_RESP_RDY_ER = 2'b10
   } type_ycr1_mem_resp_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      DONE      = 2'd3
   } ycr1_tarb_state_e;

   typedef struct packed {
      logic                   cmd;
      logic [1:0]             width;
      logic [DMEM_AWIDTH-1:0] addr;
      logic [DMEM_DWIDTH-1:0] wdata;
   } ycr1_tarb_req_s;

endpackage

// File: rtl/ycr1_rr_arb2.sv
// Two-way round-robin pick: the requester that did not win last time wins a tie.
// Purely combinational; the caller owns the last_grant register.
module ycr1_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ycr1_timer_arb.sv
// Two-master arbiter/sequencer in front of the timer MMIO port: grants one master,
// replays its request to the timer and routes the response (or a timeout error) back.
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

module ycr1_timer_arb
   import ycr1_timer_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4,
   parameter int CNT_W       = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         m0_req,
   input  logic                         m0_cmd,
   input  logic [1:0]                   m0_width,
   input  logic [`YCR1_DMEM_AWIDTH-1:0] m0_addr,
   input  logic [`YCR1_DMEM_DWIDTH-1:0] m0_wdata,
   output logic                         m0_req_ack,
   output logic [`YCR1_DMEM_DWIDTH-1:0] m0_rdata,
   output logic [1:0]                   m0_resp,

   input  logic                         m1_req,
   input  logic                         m1_cmd,
   input  logic [1:0]                   m1_width,
   input  logic [`YCR1_DMEM_AWIDTH-1:0] m1_addr,
   input  logic [`YCR1_DMEM_DWIDTH-1:0] m1_wdata,
   output logic                         m1_req_ack,
   output logic [`YCR1_DMEM_DWIDTH-1:0] m1_rdata,
   output logic [1:0]                   m1_resp,

   output logic                         tmr_req,
   output logic                         tmr_cmd,
   output logic [1:0]                   tmr_width,
   output logic [`YCR1_DMEM_AWIDTH-1:0] tmr_addr,
   output logic [`YCR1_DMEM_DWIDTH-1:0] tmr_wdata,
   input  logic                         tmr_req_ack,
   input  logic [`YCR1_DMEM_DWIDTH-1:0] tmr_rdata,
   input  logic [1:0]                   tmr_resp
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   ycr1_tarb_state_e state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             owner_q, owner_d;
   ycr1_tarb_req_s   req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic                         m0_req_ack_d, m1_req_ack_d, tmr_req_d;
   logic [1:0]                   m0_resp_d, m1_resp_d;
   logic [`YCR1_DMEM_DWIDTH-1:0] m0_rdata_d, m1_rdata_d;

   logic [1:0]     gnt;
   ycr1_tarb_req_s m0_fields, m1_fields;

   assign m0_fields = '{cmd: m0_cmd, width: m0_width, addr: m0_addr, wdata: m0_wdata};
   assign m1_fields = '{cmd: m1_cmd, width: m1_width, addr: m1_addr, wdata: m1_wdata};

   ycr1_rr_arb2 u_rr (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   // Timer-facing fields come straight from the latch so they stay stable for the whole transfer.
   assign tmr_cmd   = req_q.cmd;
   assign tmr_width = req_q.width;
   assign tmr_addr  = req_q.addr;
   assign tmr_wdata = req_q.wdata;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      req_d        = req_q;
      cnt_d        = cnt_q;
      m0_req_ack_d = 1'b0;
      m1_req_ack_d = 1'b0;
      tmr_req_d    = 1'b0;
      m0_resp_d    = YCR1_MEM_RESP_NOTRDY;
      m1_resp_d    = YCR1_MEM_RESP_NOTRDY;
      m0_rdata_d   = '0;
      m1_rdata_d   = '0;

      case (state_q)
         IDLE: begin
            if (|gnt) begin
               req_d        = gnt[1] ? m1_fields : m0_fields;
               last_grant_d = gnt[1];
               owner_d      = gnt[1];
               m0_req_ack_d = gnt[0];
               m1_req_ack_d = gnt[1];
               tmr_req_d    = 1'b1;
               state_d      = ISSUE;
            end
         end

         ISSUE: begin
            if (tmr_req_ack) begin
               cnt_d   = '0;
               state_d = WAIT_RESP;
            end else begin
               tmr_req_d = 1'b1;
            end
         end

         WAIT_RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A real response beats a timeout that expires in the same cycle.
            if (tmr_resp != YCR1_MEM_RESP_NOTRDY) begin
               state_d = DONE;
               if (owner_q) begin
                  m1_resp_d  = tmr_resp;
                  m1_rdata_d = tmr_rdata;
               end else begin
                  m0_resp_d  = tmr_resp;
                  m0_rdata_d = tmr_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               if (owner_q) m1_resp_d = YCR1_MEM_RESP_RDY_ER;
               else         m0_resp_d = YCR1_MEM_RESP_RDY_ER;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         req_q        <= '0;
         cnt_q        <= '0;
         m0_req_ack   <= 1'b0;
         m1_req_ack   <= 1'b0;
         tmr_req      <= 1'b0;
         m0_resp      <= YCR1_MEM_RESP_NOTRDY;
         m1_resp      <= YCR1_MEM_RESP_NOTRDY;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
         m0_req_ack   <= m0_req_ack_d;
         m1_req_ack   <= m1_req_ack_d;
         tmr_req      <= tmr_req_d;
         m0_resp      <= m0_resp_d;
         m1_resp      <= m1_resp_d;
         m0_rdata     <= m0_rdata_d;
         m1_rdata     <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_ycr1_timer_arb.sv
// Bench for ycr1_timer_arb: directed scenarios then randomized two-master traffic,
// checked against a transaction-level model of grant order, results and latency.
module tb_ycr1_timer_arb;
   import ycr1_timer_arb_pkg::*;

   localparam int AW = DMEM_AWIDTH;
   localparam int DW = DMEM_DWIDTH;
   localparam int TO = 4;
   localparam logic [1:0] W_WORD = 2'b10, W_HWORD = 2'b01;
   localparam logic [1:0] R_OK = 2'b01, R_ER = 2'b10;

   typedef struct {
      bit          cmd;
      bit [1:0]    width;
      bit [AW-1:0] addr;
      bit [DW-1:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          m0_req, m0_cmd, m0_req_ack, m1_req, m1_cmd, m1_req_ack;
   logic [1:0]    m0_width, m0_resp, m1_width, m1_resp;
   logic [AW-1:0] m0_addr, m1_addr, tmr_addr;
   logic [DW-1:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, tmr_wdata, tmr_rdata;
   logic          tmr_req, tmr_cmd, tmr_req_ack;
   logic [1:0]    tmr_width, tmr_resp;

   ycr1_timer_arb #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
      .tmr_req(tmr_req), .tmr_cmd(tmr_cmd), .tmr_width(tmr_width), .tmr_addr(tmr_addr),
      .tmr_wdata(tmr_wdata), .tmr_req_ack(tmr_req_ack), .tmr_rdata(tmr_rdata), .tmr_resp(tmr_resp)
   );

   // Legal timer access: aligned word inside CONTROL..MTIMECMPHI (0x00..0x14).
   function automatic bit tmr_ok(input logic [1:0] w, input logic [AW-1:0] a);
      return (w == W_WORD) && (a[1:0] == 2'b00) && (a < 32'h18);
   endfunction

   function automatic logic [DW-1:0] preset(input int i);
      return (i == 2) ? 32'h0000_0123 : 32'h0000_00A0 + i;
   endfunction

   // Timer stand-in: ack one cycle after req, response one cycle after ack, silent on illegal access.
   logic [DW-1:0] tregs [0:7];
   bit            tmr_loaded = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_req_ack <= 1'b0;
         tmr_resp    <= 2'b00;
         tmr_rdata   <= '0;
         if (!tmr_loaded) begin
            for (int i = 0; i < 8; i++) tregs[i] <= preset(i);
            tmr_loaded <= 1'b1;
         end
      end else begin
         tmr_req_ack <= tmr_req && !tmr_req_ack;
         tmr_resp    <= 2'b00;
         tmr_rdata   <= '0;
         if (tmr_req && tmr_req_ack && tmr_ok(tmr_width, tmr_addr)) begin
            tmr_resp <= R_OK;
            if (tmr_cmd) tregs[tmr_addr[4:2]] <= tmr_wdata;
            else         tmr_rdata <= tregs[tmr_addr[4:2]];
         end
      end
   end

   int checks = 0, errs = 0, cyc = 0;
   int ref_last = 1;
   logic [DW-1:0] ref_regs [0:7];
   txn_t q0[$], q1[$];
   int last_ack_cyc0, last_ack_cyc1, last_resp_cyc0, last_resp_cyc1, n_ack0, n_ack1;
   logic [DW-1:0] last_rd0, last_rd1;
   logic [1:0]    last_rv0, last_rv1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1; cyc++;
   endtask

   function automatic txn_t mk(input bit c, input bit [1:0] w, input bit [AW-1:0] a, input bit [DW-1:0] d);
      txn_t t;
      t.cmd = c; t.width = w; t.addr = a; t.wdata = d;
      return t;
   endfunction

   task automatic drive0(input txn_t t);
      m0_cmd = t.cmd; m0_width = t.width; m0_addr = t.addr; m0_wdata = t.wdata;
   endtask

   task automatic drive1(input txn_t t);
      m1_cmd = t.cmd; m1_width = t.width; m1_addr = t.addr; m1_wdata = t.wdata;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      tick(); tick();
      rst_n = 1'b1; ref_last = 1;
      tick();
   endtask

   task automatic regs_chk(input string tag);
      for (int i = 0; i < 6; i++) chk(tag, tregs[i], ref_regs[i]);
   endtask

   // Plays queued transactions for both masters until all have been answered.
   task automatic run(input int budget);
      txn_t cur;
      bit out0, out1, pa0, pa1, p0, p1, ok;
      int w, ew, ack_c0, ack_c1, lat0, lat1, last_resp;
      logic [1:0] er0, er1;
      logic [DW-1:0] ed0, ed1;
      out0 = 0; out1 = 0; pa0 = 0; pa1 = 0; last_resp = -1;
      ack_c0 = 0; ack_c1 = 0; lat0 = 0; lat1 = 0; er0 = 0; er1 = 0; ed0 = 0; ed1 = 0;
      n_ack0 = 0; n_ack1 = 0;
      cyc = 0;
      if (q0.size() > 0) begin drive0(q0[0]); m0_req = 1'b1; end
      if (q1.size() > 0) begin drive1(q1[0]); m1_req = 1'b1; end
      while ((q0.size() > 0 || q1.size() > 0 || out0 || out1) && cyc < budget) begin
         tick();
         chk("ack_excl", m0_req_ack & m1_req_ack, 0);
         chk("ack0_pulse", pa0 & m0_req_ack, 0);
         chk("ack1_pulse", pa1 & m1_req_ack, 0);
         pa0 = m0_req_ack; pa1 = m1_req_ack;
         if (m0_req_ack || m1_req_ack) begin
            w  = m1_req_ack ? 1 : 0;
            p0 = q0.size() > 0; p1 = q1.size() > 0;
            ew = (p0 && p1) ? (1 - ref_last) : (p1 ? 1 : 0);
            chk("grant", w, ew);
            if (last_resp >= 0) chk("ack_gap", cyc, last_resp + 2);
            else                chk("first_ack", cyc, 1);
            if ((w == 1) ? !p1 : !p0) chk("spurious_ack", 1, 0);
            else begin
               ref_last = w;
               cur = (w == 1) ? q1.pop_front() : q0.pop_front();
               chk("tmr_req", tmr_req, 1);
               chk("tmr_addr", tmr_addr, cur.addr);
               chk("tmr_wdata", tmr_wdata, cur.wdata);
               chk("tmr_cmdw", {tmr_cmd, tmr_width}, {cur.cmd, cur.width});
               ok = tmr_ok(cur.width, cur.addr);
               if (w == 1) begin
                  er1 = ok ? R_OK : R_ER;
                  ed1 = (ok && !cur.cmd) ? ref_regs[cur.addr[4:2]] : '0;
                  lat1 = ok ? 3 : TO + 2; out1 = 1; ack_c1 = cyc; last_ack_cyc1 = cyc; n_ack1++;
                  if (q1.size() > 0) drive1(q1[0]); else m1_req = 1'b0;
               end else begin
                  er0 = ok ? R_OK : R_ER;
                  ed0 = (ok && !cur.cmd) ? ref_regs[cur.addr[4:2]] : '0;
                  lat0 = ok ? 3 : TO + 2; out0 = 1; ack_c0 = cyc; last_ack_cyc0 = cyc; n_ack0++;
                  if (q0.size() > 0) drive0(q0[0]); else m0_req = 1'b0;
               end
               if (ok && cur.cmd) ref_regs[cur.addr[4:2]] = cur.wdata;
            end
         end
         chk("resp_excl", (m0_resp != 2'b00) && (m1_resp != 2'b00), 0);
         chk("rdata0_idle", (m0_resp == 2'b00) && (m0_rdata != '0), 0);
         chk("rdata1_idle", (m1_resp == 2'b00) && (m1_rdata != '0), 0);
         if (m0_resp != 2'b00) begin
            if (!out0) chk("spurious_resp0", 1, 0);
            else begin
               chk("resp0", m0_resp, er0); chk("rdata0", m0_rdata, ed0);
               chk("lat0", cyc - ack_c0, lat0);
               out0 = 0; last_resp = cyc; last_resp_cyc0 = cyc; last_rd0 = m0_rdata; last_rv0 = m0_resp;
            end
         end
         if (m1_resp != 2'b00) begin
            if (!out1) chk("spurious_resp1", 1, 0);
            else begin
               chk("resp1", m1_resp, er1); chk("rdata1", m1_rdata, ed1);
               chk("lat1", cyc - ack_c1, lat1);
               out1 = 0; last_resp = cyc; last_resp_cyc1 = cyc; last_rd1 = m1_rdata; last_rv1 = m1_resp;
            end
         end
      end
      chk("run_done", (q0.size() > 0) || (q1.size() > 0) || out0 || out1, 0);
      q0.delete(); q1.delete(); m0_req = 1'b0; m1_req = 1'b0;
      tick();
      chk("quiet", {m0_resp, m1_resp, m0_req_ack, m1_req_ack}, 0);
   endtask

   initial begin
      int n0, n1;
      for (int i = 0; i < 8; i++) ref_regs[i] = preset(i);
      rst_n = 1'b0; m0_req = 0; m1_req = 0;
      drive0(mk(0, 0, 0, 0)); drive1(mk(0, 0, 0, 0));
      #1;
      chk("reset_outs", |{m0_req_ack, m0_rdata, m0_resp, m1_req_ack, m1_rdata, m1_resp,
                          tmr_req, tmr_cmd, tmr_width, tmr_addr, tmr_wdata}, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // M0 alone reads MTIMELO
      q0.push_back(mk(0, W_WORD, 32'h08, 0));
      run(40);
      chk("s1_ack_cyc", last_ack_cyc0, 1);
      chk("s1_resp_cyc", last_resp_cyc0, 4);
      chk("s1_rdata", last_rd0, 32'h123);

      // Simultaneous writes to MTIMECMPLO from reset
      do_reset();
      q0.push_back(mk(1, W_WORD, 32'h10, 32'h10));
      q1.push_back(mk(1, W_WORD, 32'h10, 32'h20));
      run(40);
      chk("s2_m0_ack", last_ack_cyc0, 1);
      chk("s2_m1_ack", last_ack_cyc1, 6);
      chk("s2_cmplo", tregs[4], 32'h20);
      regs_chk("s2_regs");

      // Continuous dual requests, three each
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(0, W_WORD, 32'h08, 0));
         q1.push_back(mk(1, W_WORD, 32'h14, 32'h100 + i));
      end
      run(80);
      chk("s3_n0", n_ack0, 3);
      chk("s3_n1", n_ack1, 3);

      // Half-word read that the timer never answers, then a normal one
      q1.push_back(mk(0, W_HWORD, 32'h08, 0));
      run(40);
      chk("s4_resp", last_rv1, R_ER);
      chk("s4_rdata", last_rd1, 0);
      chk("s4_resp_cyc", last_resp_cyc1, 3 + TO);
      q1.push_back(mk(0, W_WORD, 32'h0C, 0));
      run(40);
      chk("s4_next_resp", last_rv1, R_OK);

      // Out-of-range read
      q0.push_back(mk(0, W_WORD, 32'h1C, 0));
      run(40);
      chk("s5_resp", last_rv0, R_ER);
      chk("s5_resp_cyc", last_resp_cyc0, 3 + TO);
      regs_chk("s5_regs");

      // Reset while waiting for a response
      drive0(mk(0, W_HWORD, 32'h08, 0));
      m0_req = 1'b1; cyc = 0;
      tick();
      chk("s6_ack", m0_req_ack, 1);
      m0_req = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0; #1;
      chk("s6_rst_outs", |{m0_req_ack, m0_rdata, m0_resp, m1_req_ack, m1_rdata, m1_resp,
                           tmr_req, tmr_cmd, tmr_width, tmr_addr, tmr_wdata}, 0);
      tick(); tick();
      rst_n = 1'b1; ref_last = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("s6_no_resp", {m0_resp, m1_resp, m0_req_ack, m1_req_ack}, 0);
      end
      q0.push_back(mk(0, W_WORD, 32'h08, 0));
      run(40);
      chk("s6_resp", last_rv0, R_OK);
      chk("s6_resp_cyc", last_resp_cyc0, 4);

      // Randomized traffic
      for (int r = 0; r < 12; r++) begin
         n0 = $urandom_range(0, 3);
         n1 = $urandom_range(0, 3);
         if (n0 + n1 == 0) n0 = 1;
         for (int i = 0; i < n0 + n1; i++) begin
            txn_t t;
            t = mk($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? W_HWORD : W_WORD,
                   32'($urandom_range(0, 7) * 4), $urandom);
            if (i < n0) q0.push_back(t); else q1.push_back(t);
         end
         run(12 * (n0 + n1) + 10);
      end
      regs_chk("final_regs");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
